light_sequencer: RTL and testbench

LIGHT_SEQUENCER -- requirements
Module: light_sequencer

---
 rtl/light_sequencer.sv | 134 +++++++++++++
 tb/tb_light_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/light_sequencer.sv
// rtl/light_sequencer.sv - two-approach traffic light sequencer with pedestrian walk phase
module light_sequencer #(
    parameter int GREEN_LEN  = 20,
    parameter int YELLOW_LEN = 4,
    parameter int ALLRED_LEN = 2,
    parameter int WALK_LEN   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_ns,
    input  logic       car_ew,
    input  logic       ped_req,
    input  logic       t_done,
    input  logic       t_flicker,
    output logic       t_start,
    output logic [4:0] t_length,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic       walk_flash
);

    typedef enum logic [2:0] {
        ALLRED_A  = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALLRED_B  = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        PED_WALK  = 3'd6
    } state_t;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    state_t state;
    state_t state_next;
    logic   entry;
    logic   post_reset;
    logic   ped_pending;
    logic   ped_pending_next;
    logic   next_dir;
    logic   next_dir_next;
    logic   advance;
    logic   ped_eff;

    // post_reset holds the sequencer still for one cycle so the first
    // entry pulse lands after reset is released, and masks any stale done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ALLRED_A;
            entry       <= 1'b0;
            post_reset  <= 1'b1;
            ped_pending <= 1'b0;
            next_dir    <= DIR_NS;
        end else begin
            state       <= state_next;
            entry       <= advance | post_reset;
            post_reset  <= 1'b0;
            ped_pending <= ped_pending_next;
            next_dir    <= next_dir_next;
        end
    end

    assign advance = t_done & ~entry & ~post_reset;

    // A request arriving in the same cycle as a dwell ends already counts.
    assign ped_eff = ped_pending | (ped_req & (state != PED_WALK));

    always_comb begin
        state_next    = state;
        next_dir_next = next_dir;
        if (advance) begin
            unique case (state)
                ALLRED_A: begin
                    next_dir_next = DIR_NS;
                    state_next    = ped_eff ? PED_WALK : NS_GREEN;
                end
                NS_GREEN:  state_next = (car_ew | ped_eff) ? NS_YELLOW : NS_GREEN;
                NS_YELLOW: state_next = ALLRED_B;
                ALLRED_B: begin
                    next_dir_next = DIR_EW;
                    state_next    = ped_eff ? PED_WALK : EW_GREEN;
                end
                EW_GREEN:  state_next = (car_ns | ped_eff) ? EW_YELLOW : EW_GREEN;
                EW_YELLOW: state_next = ALLRED_A;
                PED_WALK:  state_next = (next_dir == DIR_EW) ? EW_GREEN : NS_GREEN;
                default:   state_next = ALLRED_A;
            endcase
        end
    end

    always_comb begin
        ped_pending_next = ped_eff;
        if (advance && (state_next == PED_WALK)) begin
            ped_pending_next = 1'b0;
        end
    end

    always_comb begin
        ns_light = LIGHT_RED;
        ew_light = LIGHT_RED;
        t_length = 5'(ALLRED_LEN);
        unique case (state)
            NS_GREEN: begin
                ns_light = LIGHT_GREEN;
                t_length = 5'(GREEN_LEN);
            end
            NS_YELLOW: begin
                ns_light = LIGHT_YELLOW;
                t_length = 5'(YELLOW_LEN);
            end
            EW_GREEN: begin
                ew_light = LIGHT_GREEN;
                t_length = 5'(GREEN_LEN);
            end
            EW_YELLOW: begin
                ew_light = LIGHT_YELLOW;
                t_length = 5'(YELLOW_LEN);
            end
            PED_WALK:  t_length = 5'(WALK_LEN);
            default:   t_length = 5'(ALLRED_LEN);
        endcase
    end

    assign t_start    = entry;
    assign walk       = (state == PED_WALK);
    assign walk_flash = walk & t_flicker;

endmodule

// File: tb/tb_light_sequencer.sv
// tb/tb_light_sequencer.sv - directed table-driven bench for light_sequencer with a paired timer
module tb_light_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       car_ns = 1'b0;
    logic       car_ew = 1'b0;
    logic       ped_req = 1'b0;
    logic       t_done;
    logic       t_flicker;
    logic       t_start;
    logic [4:0] t_length;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic       walk_flash;

    int checks = 0;
    int errors = 0;

    light_sequencer dut (
        .clk(clk), .reset(reset), .car_ns(car_ns), .car_ew(car_ew),
        .ped_req(ped_req), .t_done(t_done), .t_flicker(t_flicker),
        .t_start(t_start), .t_length(t_length), .ns_light(ns_light),
        .ew_light(ew_light), .walk(walk), .walk_flash(walk_flash)
    );

    always #5 clk = ~clk;

    // Paired timer: done rises one cycle after the count reaches the length
    // and stays high until the next start pulse.
    logic [5:0] tcnt = 6'd0;
    logic       tdone = 1'b0;
    always @(posedge clk) begin
        if (t_start) begin
            tcnt  <= 6'd1;
            tdone <= 1'b0;
        end else begin
            if (tcnt < 6'd63) tcnt <= tcnt + 6'd1;
            if (int'(tcnt) >= int'(t_length)) tdone <= 1'b1;
        end
    end
    assign t_done    = tdone;
    assign t_flicker = !tdone && !t_start && (int'(tcnt) + 2 >= int'(t_length));

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    typedef struct {
        logic       c_ns;
        logic       c_ew;
        int         ped_at;
        logic [2:0] ns;
        logic [2:0] ew;
        int         len;
        int         dwell;
        logic       wk;
    } phase_t;

    phase_t tbl[19];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_dwell(output int n);
        n = 1;
        step();
        while (!t_start && n < 100) begin
            n++;
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        int         n;
        int         stable_bad;
        int         flash_bad;
        int         flicker_seen;
        logic [2:0] ns0;
        logic [2:0] ew0;
        bit         found;

        tbl[0]  = '{1'b1, 1'b1, -1, R, R,  2,  4, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, -1, G, R, 20, 22, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, -1, Y, R,  4,  6, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, -1, R, R,  2,  4, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, -1, R, G, 20, 22, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, -1, R, Y,  4,  6, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, -1, R, R,  2,  4, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, -1, G, R, 20, 22, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 21, G, R, 20, 22, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, -1, Y, R,  4,  6, 1'b0};
        tbl[10] = '{1'b0, 1'b0, -1, R, R,  2,  4, 1'b0};
        tbl[11] = '{1'b0, 1'b0, -1, R, R, 10, 12, 1'b1};
        tbl[12] = '{1'b0, 1'b0, -1, R, G, 20, 22, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 10, R, G, 20, 22, 1'b0};
        tbl[14] = '{1'b0, 1'b0, -1, R, Y,  4,  6, 1'b0};
        tbl[15] = '{1'b0, 1'b0, -1, R, R,  2,  4, 1'b0};
        tbl[16] = '{1'b0, 1'b0,  3, R, R, 10, 12, 1'b1};
        tbl[17] = '{1'b0, 1'b0, -1, G, R, 20, 22, 1'b0};
        tbl[18] = '{1'b1, 1'b1, -1, G, R, 20, 22, 1'b0};

        reset = 1'b1;
        step();
        step();
        check("rst_t_start", int'(t_start), 0);
        check("rst_ns", int'(ns_light), int'(R));
        check("rst_ew", int'(ew_light), int'(R));
        check("rst_walk", int'(walk), 0);
        check("rst_walk_flash", int'(walk_flash), 0);
        reset = 1'b0;
        step();
        check("first_t_start", int'(t_start), 1);
        check("first_t_length", int'(t_length), 2);

        for (int i = 0; i < 19; i++) begin
            car_ns = tbl[i].c_ns;
            car_ew = tbl[i].c_ew;
            ns0 = ns_light;
            ew0 = ew_light;
            stable_bad = 0;
            flash_bad = 0;
            flicker_seen = 0;
            check($sformatf("ph%0d_t_start", i), int'(t_start), 1);
            check($sformatf("ph%0d_ns", i), int'(ns_light), int'(tbl[i].ns));
            check($sformatf("ph%0d_ew", i), int'(ew_light), int'(tbl[i].ew));
            check($sformatf("ph%0d_t_length", i), int'(t_length), tbl[i].len);
            check($sformatf("ph%0d_walk", i), int'(walk), int'(tbl[i].wk));
            ped_req = (tbl[i].ped_at == 0);
            cyc = 1;
            while (1) begin
                step();
                ped_req = (cyc == tbl[i].ped_at);
                if (t_start || cyc >= 100) break;
                if (ns_light !== ns0 || ew_light !== ew0 || int'(t_length) != tbl[i].len) stable_bad++;
                if (walk_flash !== (tbl[i].wk & t_flicker)) flash_bad++;
                if (walk_flash) flicker_seen++;
                cyc++;
            end
            ped_req = 1'b0;
            check($sformatf("ph%0d_dwell", i), cyc, tbl[i].dwell);
            check($sformatf("ph%0d_stable", i), stable_bad, 0);
            check($sformatf("ph%0d_flash", i), flash_bad, 0);
            if (tbl[i].wk) check($sformatf("ph%0d_flash_seen", i), int'(flicker_seen > 0), 1);
        end

        car_ns = 1'b1;
        car_ew = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            step();
            if (t_start && ew_light == G) found = 1'b1;
        end
        check("reach_ew_green", int'(found), 1);
        for (int k = 0; k < 10; k++) step();
        reset = 1'b1;
        step();
        check("midrst_ns", int'(ns_light), int'(R));
        check("midrst_ew", int'(ew_light), int'(R));
        check("midrst_t_start", int'(t_start), 0);
        reset = 1'b0;
        step();
        check("midrst_restart", int'(t_start), 1);
        check("midrst_len", int'(t_length), 2);
        run_dwell(n);
        check("midrst_allred_dwell", n, 4);
        check("midrst_next_ns", int'(ns_light), int'(G));

        for (int k = 0; k < 21; k++) step();
        check("stale_done_high", int'(t_done), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("stale_t_start", int'(t_start), 1);
        check("stale_done_held", int'(t_done), 1);
        run_dwell(n);
        check("stale_allred_dwell", n, 4);
        check("stale_next_ns", int'(ns_light), int'(G));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
